// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address-field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned INDEX_W = 8;
    localparam int unsigned TAG_W   = 22;
    localparam int unsigned LINES   = 256;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_e;

    function automatic logic [INDEX_W-1:0] pc_index(input logic [ADDR_W-1:0] pc);
        return pc[9:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [ADDR_W-1:0] pc);
        return pc[31:10];
    endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 256 one-word lines, one-cycle
// hits, single outstanding miss to the memory controller.
module icache
    import icache_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              jump_or_not_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_pc_in,
    output logic              if_valid_out,
    output logic [DATA_W-1:0] if_inst_out,
    output logic              mc_inst_enable_out,
    output logic [ADDR_W-1:0] mc_inst_address_out,
    input  logic              mc_inst_valid_in,
    input  logic [DATA_W-1:0] mc_inst_data_in,
    output state_e            dbg_state_out
);

    // Handshake: if_req_in is held until the one-cycle if_valid_out pulse;
    // mc_inst_enable_out is held until the one-cycle mc_inst_valid_in pulse.

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic                if_valid_q, if_valid_d;
    logic [DATA_W-1:0]   if_inst_q, if_inst_d;
    logic [LINES-1:0]    valid_q;
    logic [DATA_W-1:0]   data_q [LINES];
    logic [TAG_W-1:0]    tag_q  [LINES];

    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]    miss_tag;
    logic                hit;
    logic                fill_we;
    logic                unused_pc_bits;

    assign req_idx  = pc_index(if_pc_in);
    assign req_tag  = pc_tag(if_pc_in);
    assign miss_idx = pc_index(miss_addr_q);
    assign miss_tag = pc_tag(miss_addr_q);
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Byte offset within the word plays no part in lookup.
    assign unused_pc_bits = &{1'b0, if_pc_in[1:0]};

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        if_valid_d  = 1'b0;
        if_inst_d   = if_inst_q;
        fill_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!jump_or_not_in && if_req_in) begin
                    if (hit) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = data_q[req_idx];
                    end else begin
                        miss_addr_d = if_pc_in;
                        state_d     = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                // A returning fill is always installed, even if a redirect
                // arrives the same cycle; only the delivery is suppressed.
                fill_we = mc_inst_valid_in;
                if (jump_or_not_in) begin
                    state_d = ST_IDLE;
                end else if (mc_inst_valid_in) begin
                    state_d    = ST_IDLE;
                    if_valid_d = 1'b1;
                    if_inst_d  = mc_inst_data_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if_valid_q  <= if_valid_d;
            if_inst_q   <= if_inst_d;
            if (fill_we) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Data and tag storage is gated by valid_q, so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            data_q[miss_idx] <= mc_inst_data_in;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

    assign if_valid_out        = if_valid_q;
    assign if_inst_out         = if_inst_q;
    assign mc_inst_enable_out  = (state_q == ST_MISS) && !mc_inst_valid_in;
    assign mc_inst_address_out = (state_q == ST_MISS) ? miss_addr_q : '0;
    assign dbg_state_out       = state_q;

endmodule
